tb_int_driver: RTL

TB_INT_DRIVER -- requirements
Module: tb_int_driver

---
 rtl/tb_int_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/tb_int_driver.sv
// Interrupt stimulus driver: raises an interrupt at a trigger PC, tracks the
// ack / handler-entry / return round trip, and records EPC and latency.
module tb_int_driver #(
  parameter logic [31:0] TRIG_PC    = 32'h0000_3010,
  parameter logic [31:0] ACK_ADDR   = 32'h0000_7F20,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned GAP        = 8,
  parameter int unsigned MAX_INT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_data_addr,
  input  logic [3:0]  m_data_byteen,
  output logic        interrupt,
  output logic [7:0]  int_count,
  output logic [31:0] epc_q,
  output logic [15:0] latency,
  output logic        timeout_err,
  output logic        done,
  output logic [2:0]  state
);

  localparam int unsigned TW = 16;
  localparam int unsigned CW = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ASSERT  = 3'd1;
  localparam logic [2:0] S_HANDLER = 3'd2;
  localparam logic [2:0] S_RETURN  = 3'd3;
  localparam logic [2:0] S_COOL    = 3'd4;
  localparam logic [2:0] S_STOP    = 3'd5;

  logic [2:0]    r_state,      w_state_nxt;
  logic          r_interrupt,  w_int_nxt;
  logic [TW-1:0] r_wait,       w_wait_nxt;
  logic [TW-1:0] r_gap,        w_gap_nxt;
  logic [TW-1:0] r_lat_cnt,    w_lat_cnt_nxt;
  logic [TW-1:0] r_latency,    w_lat_nxt;
  logic [CW-1:0] r_int_count,  w_cnt_nxt;
  logic          r_timeout_err, w_terr_nxt;
  logic          r_done,       w_done_nxt;
  logic [31:0]   r_epc;

  logic          w_ack;
  logic          w_tmo;
  logic          w_gap_end;
  logic [TW-1:0] w_lat_inc;

  assign w_ack     = (m_data_addr == ACK_ADDR) && (m_data_byteen != 4'd0);
  assign w_tmo     = (r_wait == TW'(TIMEOUT - 1));
  assign w_gap_end = (r_gap == TW'(GAP - 1));
  assign w_lat_inc = (r_lat_cnt == 16'hFFFF) ? r_lat_cnt : r_lat_cnt + 16'd1;

  // Next-state and datapath updates; wait/gap timers clear unless explicitly held.
  always_comb begin
    w_state_nxt   = r_state;
    w_int_nxt     = r_interrupt;
    w_wait_nxt    = '0;
    w_gap_nxt     = '0;
    w_lat_cnt_nxt = r_lat_cnt;
    w_lat_nxt     = r_latency;
    w_cnt_nxt     = r_int_count;
    w_terr_nxt    = r_timeout_err;

    case (r_state)
      S_IDLE: begin
        if ((macroscopic_pc == TRIG_PC) && !r_done) begin
          w_state_nxt   = S_ASSERT;
          w_int_nxt     = 1'b1;
          w_lat_cnt_nxt = 16'd1;
        end
      end
      S_ASSERT: begin
        w_lat_cnt_nxt = w_lat_inc;
        if (w_ack) begin
          w_state_nxt = S_HANDLER;
          w_int_nxt   = 1'b0;
        end else if (w_tmo) begin
          w_state_nxt = S_COOL;
          w_int_nxt   = 1'b0;
          w_terr_nxt  = 1'b1;
        end else begin
          w_wait_nxt = r_wait + 16'd1;
        end
      end
      S_HANDLER: begin
        if (macroscopic_pc == HANDLER_PC) begin
          w_state_nxt = S_RETURN;
          w_lat_nxt   = r_lat_cnt;
        end else if (w_tmo) begin
          w_state_nxt = S_COOL;
          w_terr_nxt  = 1'b1;
        end else begin
          w_wait_nxt    = r_wait + 16'd1;
          w_lat_cnt_nxt = w_lat_inc;
        end
      end
      S_RETURN: begin
        if (macroscopic_pc == r_epc) begin
          w_state_nxt = S_COOL;
          if (r_int_count != 8'hFF) w_cnt_nxt = r_int_count + 8'd1;
        end else if (w_tmo) begin
          w_state_nxt = S_COOL;
          w_terr_nxt  = 1'b1;
        end else begin
          w_wait_nxt = r_wait + 16'd1;
        end
      end
      S_COOL: begin
        if (w_gap_end) begin
          w_state_nxt = (r_int_count == CW'(MAX_INT)) ? S_STOP : S_IDLE;
        end else begin
          w_gap_nxt = r_gap + 16'd1;
        end
      end
      S_STOP: begin
        w_int_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_int_nxt   = 1'b0;
      end
    endcase

    w_done_nxt = (w_cnt_nxt == CW'(MAX_INT));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_interrupt   <= 1'b0;
      r_wait        <= '0;
      r_gap         <= '0;
      r_lat_cnt     <= '0;
      r_latency     <= '0;
      r_int_count   <= '0;
      r_timeout_err <= 1'b0;
      r_done        <= 1'b0;
      r_epc         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_interrupt   <= w_int_nxt;
      r_wait        <= w_wait_nxt;
      r_gap         <= w_gap_nxt;
      r_lat_cnt     <= w_lat_cnt_nxt;
      r_latency     <= w_lat_nxt;
      r_int_count   <= w_cnt_nxt;
      r_timeout_err <= w_terr_nxt;
      r_done        <= w_done_nxt;
      // EPC tracks the PC of every cycle the interrupt line is high.
      if (r_interrupt) r_epc <= macroscopic_pc;
    end
  end

  assign interrupt   = r_interrupt;
  assign int_count   = r_int_count;
  assign epc_q       = r_epc;
  assign latency     = r_latency;
  assign timeout_err = r_timeout_err;
  assign done        = r_done;
  assign state       = r_state;

endmodule
